uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 29 ++
 rtl/uart_tx.sv | 142 ++++++++++++++
 tb/tb_uart_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit/receive line FSM states and parity selection.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;
  localparam int DATA_BITS   = 8;

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: bit_end marks the last cycle of each cycles_per_bit window while run is high.
// Held at zero while run is low so every frame starts on a fresh bit period.
module uart_bit_timer #(
  parameter int cycles_per_bit = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bit_end
);

  localparam int W = (cycles_per_bit > 2) ? $clog2(cycles_per_bit) : 1;
  localparam logic [W-1:0] LAST = W'(cycles_per_bit - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_end = run && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1/8E/8O with 1-2 stop bits, LSB first; start bit on the line one edge after accept.
// One-byte holding register behind the shifter: tready drops while it is full, frames go out back-to-back.
module uart_tx
  import uart_pkg::*;
#(
  parameter int cycles_per_bit = 434,
  parameter int parity_en      = 0,
  parameter int parity_odd     = 0,
  parameter int stop_bits      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tx,
  output logic       tready,
  input  logic       tvalid,
  input  logic [7:0] tdata,
  output logic       busy
);

  if (cycles_per_bit < 2) begin : g_bad_cpb
    $error("uart_tx: cycles_per_bit must be at least 2");
  end
  if ((stop_bits != 1) && (stop_bits != 2)) begin : g_bad_stop
    $error("uart_tx: stop_bits must be 1 or 2");
  end
  if ((parity_odd != PARITY_EVEN) && (parity_odd != PARITY_ODD)) begin : g_bad_par
    $error("uart_tx: parity_odd must be 0 or 1");
  end

  localparam logic       PAR_EN    = (parity_en != 0);
  localparam logic       PAR_ODD   = (parity_odd == PARITY_ODD);
  localparam logic       LAST_STOP = (stop_bits == 2);
  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);

  state_t     r_state;
  logic [7:0] r_hold_dat;
  logic       r_hold_full;
  logic [7:0] r_shift;
  logic       r_par;
  logic [2:0] r_bit_idx;
  logic       r_stop_cnt;
  logic       r_tx;
  logic       r_tready;
  logic       r_busy;

  logic w_bit_end;
  logic w_accept;
  logic w_frame_end;
  logic w_load;
  logic w_hold_full_nxt;
  logic w_idle_nxt;

  uart_bit_timer #(
    .cycles_per_bit(cycles_per_bit)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (r_state != IDLE),
    .bit_end(w_bit_end)
  );

  // Loading on the last stop cycle is what removes the idle gap between frames.
  assign w_accept        = tvalid && r_tready;
  assign w_frame_end     = (r_state == STOP) && w_bit_end && (r_stop_cnt == LAST_STOP);
  assign w_load          = r_hold_full && ((r_state == IDLE) || w_frame_end);
  assign w_hold_full_nxt = w_load ? 1'b0 : (r_hold_full || w_accept);
  assign w_idle_nxt      = !w_load && ((r_state == IDLE) || w_frame_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold_dat  <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_bit_idx   <= '0;
      r_stop_cnt  <= 1'b0;
      r_tx        <= 1'b1;
      r_tready    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_tready    <= !w_hold_full_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_busy      <= !w_idle_nxt || w_hold_full_nxt;
      if (w_accept) begin
        r_hold_dat <= tdata;
      end
      if (w_load) begin
        r_state    <= START;
        r_tx       <= 1'b0;
        r_shift    <= r_hold_dat;
        r_par      <= parity_bit(r_hold_dat, PAR_ODD);
        r_bit_idx  <= '0;
        r_stop_cnt <= 1'b0;
      end else if (w_bit_end) begin
        case (r_state)
          START: begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end
          DATA: begin
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == LAST_IDX) begin
              if (PAR_EN) begin
                r_state <= PARITY;
                r_tx    <= r_par;
              end else begin
                r_state <= STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end
          PARITY: begin
            r_state <= STOP;
            r_tx    <= 1'b1;
          end
          STOP: begin
            if (w_frame_end) begin
              r_state    <= IDLE;
              r_tx       <= 1'b1;
              r_stop_cnt <= 1'b0;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx     = r_tx;
  assign tready = r_tready;
  assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (8N1, 8E2, 8O2) at 4 clocks per bit plus a serial loopback monitor.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic [2:0] tv    = 3'b000;
  logic       tx0, tx1, tx2;
  logic       trdy0, trdy1, trdy2;
  logic       busy0, busy1, busy2;

  int n_checks = 0;
  int n_errs   = 0;

  logic       rx_en = 1'b0;
  logic [7:0] rx_b;
  logic [7:0] tx_b;
  int         gap;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  uart_tx #(.cycles_per_bit(CPB), .parity_en(0), .parity_odd(0), .stop_bits(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .tx(tx0), .tready(trdy0), .tvalid(tv[0]), .tdata(tdata), .busy(busy0));

  uart_tx #(.cycles_per_bit(CPB), .parity_en(1), .parity_odd(0), .stop_bits(2)) u_dut_pe (
    .clk(clk), .rst_n(rst_n), .tx(tx1), .tready(trdy1), .tvalid(tv[1]), .tdata(tdata), .busy(busy1));

  uart_tx #(.cycles_per_bit(CPB), .parity_en(1), .parity_odd(1), .stop_bits(2)) u_dut_po (
    .clk(clk), .rst_n(rst_n), .tx(tx2), .tready(trdy2), .tvalid(tv[2]), .tdata(tdata), .busy(busy2));

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic tx_of(input int d);
    case (d)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic rdy_of(input int d);
    case (d)
      0:       return trdy0;
      1:       return trdy1;
      default: return trdy2;
    endcase
  endfunction

  function automatic logic busy_of(input int d);
    case (d)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  // Returns just after the accept edge with tvalid already dropped.
  task automatic send_byte(input int d, input logic [7:0] b);
    int t;
    t = 0;
    tdata = b;
    tv[d] = 1'b1;
    while (!rdy_of(d) && (t < 100)) begin
      step();
      t++;
    end
    chk_eq("tready_wait", rdy_of(d), 1'b1);
    step();
    tv[d] = 1'b0;
  endtask

  // Called right after the load edge; bits[k] is the k-th bit on the line.
  task automatic check_frame(input int d, input logic [11:0] bits, input int nbits, input string name);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        chk_eq($sformatf("%s_tx_b%0d_c%0d", name, b, c), tx_of(d), bits[b]);
        chk_eq($sformatf("%s_busy_b%0d_c%0d", name, b, c), busy_of(d), 1'b1);
        step();
      end
    end
    chk_eq($sformatf("%s_busy_end", name), busy_of(d), 1'b0);
    chk_eq($sformatf("%s_tx_end", name), tx_of(d), 1'b1);
  endtask

  initial begin : rx_mon
    forever begin
      @(negedge clk);
      if (rx_en && (tx0 === 1'b0)) begin
        repeat (CPB + CPB / 2) @(negedge clk);
        rx_b[0] = tx0;
        for (int i = 1; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_b[i] = tx0;
        end
        repeat (CPB) @(negedge clk);
        chk_eq("lb_stop", tx0, 1'b1);
        got_q.push_back(rx_b);
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [19:0] b2b;
    int t;

    // Reset held with tvalid high: nothing may be accepted.
    rst_n = 1'b0;
    tv    = 3'b111;
    tdata = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_eq("rst_tx", tx0, 1'b1);
      chk_eq("rst_tready", trdy0, 1'b0);
      chk_eq("rst_busy", busy0, 1'b0);
    end
    rst_n = 1'b1;
    tv    = 3'b000;
    chk_eq("rel_tready_lo", trdy0, 1'b0);
    step();
    chk_eq("rel_tready0", trdy0, 1'b1);
    chk_eq("rel_tready1", trdy1, 1'b1);
    chk_eq("rel_tready2", trdy2, 1'b1);

    // Single 0x55 frame.
    send_byte(0, 8'h55);
    chk_eq("t2_tready_acc", trdy0, 1'b0);
    chk_eq("t2_busy_acc", busy0, 1'b1);
    chk_eq("t2_tx_acc", tx0, 1'b1);
    step();
    chk_eq("t2_tready_back", trdy0, 1'b1);
    check_frame(0, 12'h2AA, 10, "t2");

    // Back-to-back 0xA5, 0x3C with tvalid held high.
    b2b   = {10'h278, 10'h34A};
    tdata = 8'hA5;
    tv[0] = 1'b1;
    step();
    tdata = 8'h3C;
    chk_eq("t3_tready_hold", trdy0, 1'b0);
    step();
    for (int k = 0; k < 80; k++) begin
      chk_eq($sformatf("t3_tx_%0d", k), tx0, b2b[k / CPB]);
      chk_eq($sformatf("t3_busy_%0d", k), busy0, 1'b1);
      chk_eq($sformatf("t3_tready_%0d", k), trdy0, ((k == 0) || (k >= 40)) ? 1'b1 : 1'b0);
      step();
      if (k == 0) tv[0] = 1'b0;
    end
    chk_eq("t3_busy_end", busy0, 1'b0);
    chk_eq("t3_tx_end", tx0, 1'b1);

    // 0x07 with two stop bits: even parity bit 1, odd parity bit 0.
    send_byte(1, 8'h07);
    step();
    check_frame(1, 12'hE0E, 12, "t4e");
    send_byte(2, 8'h07);
    step();
    check_frame(2, 12'hC0E, 12, "t4o");

    // Reset during data bit 3 of 0xF0, then a clean 0x81.
    send_byte(0, 8'hF0);
    step();
    repeat (17) step();
    chk_eq("t5_pre_tx", tx0, 1'b0);
    chk_eq("t5_pre_busy", busy0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_eq("t5_rst_tx", tx0, 1'b1);
    chk_eq("t5_rst_tready", trdy0, 1'b0);
    chk_eq("t5_rst_busy", busy0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk_eq("t5_rel_tready", trdy0, 1'b1);
    chk_eq("t5_rel_tx", tx0, 1'b1);
    send_byte(0, 8'h81);
    step();
    check_frame(0, 12'h302, 10, "t5");

    // Loopback through the bench receiver with random gaps.
    rx_en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      gap = $urandom_range(0, 4);
      repeat (gap) step();
      tx_b = 8'($urandom_range(0, 255));
      send_byte(0, tx_b);
      exp_q.push_back(tx_b);
    end
    t = 0;
    while (busy0 && (t < 200)) begin
      step();
      t++;
    end
    chk_eq("lb_idle", busy0, 1'b0);
    repeat (4) step();
    chk_eq("lb_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk_eq($sformatf("lb_byte_%0d", i), got_q[i], exp_q[i]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
